// File: rtl/pixel_burst_gen.sv
// Pixel-to-XRGB8888 burst former: turns 8x8 decoder blocks into one clipped
// address request per visible block row followed by that row's data words.
module pixel_burst_gen #(
  parameter logic [7:0] ALPHA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  output logic        idle_o,
  input  logic [31:0] cfg_base_i,
  input  logic [31:0] cfg_stride_i,
  input  logic [15:0] cfg_width_i,
  input  logic [15:0] cfg_height_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic [15:0] pix_bx_i,
  input  logic [15:0] pix_by_i,
  input  logic [23:0] pix_rgb_i,
  output logic        addr_valid_o,
  input  logic        addr_ready_i,
  output logic [31:0] addr_o,
  output logic [2:0]  len_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic [31:0] data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] bx_q, bx_d;
  logic [15:0] by_q, by_d;
  logic [31:0] row_addr_q, row_addr_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [3:0]  vis_q, vis_d;

  logic [15:0] span_s;
  logic [3:0]  vis_calc_s;
  logic [31:0] row_off_s;
  logic        row0_vis_s;
  logic        row_vis_s;
  logic        next_row_vis_s;
  logic        in_span_s;
  logic        xfer_s;

  // Block geometry: visible columns and row visibility (17-bit compares so by+row never wraps)
  always_comb begin
    span_s     = cfg_width_i - bx_q;
    row_off_s  = {16'd0, by_q} * cfg_stride_i;
    if (bx_q >= cfg_width_i) begin
      vis_calc_s = 4'd0;
    end else if (span_s >= 16'd8) begin
      vis_calc_s = 4'd8;
    end else begin
      vis_calc_s = span_s[3:0];
    end
    row0_vis_s     = (vis_calc_s != 4'd0) && ({1'b0, by_q} < {1'b0, cfg_height_i});
    row_vis_s      = (vis_q != 4'd0) &&
                     (({1'b0, by_q} + {14'd0, row_q}) < {1'b0, cfg_height_i});
    next_row_vis_s = (vis_q != 4'd0) &&
                     (({1'b0, by_q} + {14'd0, row_q} + 17'd1) < {1'b0, cfg_height_i});
    in_span_s      = row_vis_s && ({1'b0, col_q} < vis_q);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    row_addr_d   = row_addr_q;
    row_d        = row_q;
    col_d        = col_q;
    vis_d        = vis_q;
    pix_ready_o  = 1'b0;
    addr_valid_o = 1'b0;
    data_valid_o = 1'b0;
    xfer_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix_valid_i) begin
          bx_d    = pix_bx_i & 16'hFFF8;
          by_d    = pix_by_i & 16'hFFF8;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        row_addr_d = cfg_base_i + row_off_s + {14'd0, bx_q, 2'b00};
        row_d      = 3'd0;
        col_d      = 3'd0;
        vis_d      = vis_calc_s;
        state_d    = row0_vis_s ? ADDR : DATA;
      end
      ADDR: begin
        addr_valid_o = 1'b1;
        if (addr_ready_i) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        // Columns beyond the image edge (or whole invisible rows) drain unconditionally
        if (in_span_s) begin
          data_valid_o = pix_valid_i;
          pix_ready_o  = data_ready_i;
          xfer_s       = pix_valid_i && data_ready_i;
        end else begin
          pix_ready_o  = 1'b1;
          xfer_s       = pix_valid_i;
        end
        if (xfer_s) begin
          if (col_q == 3'd7) begin
            col_d      = 3'd0;
            row_d      = row_q + 3'd1;
            row_addr_d = row_addr_q + cfg_stride_i;
            if (row_q == 3'd7) begin
              state_d = IDLE;
            end else if (next_row_vis_s) begin
              state_d = ADDR;
            end else begin
              state_d = DATA;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; flush clears everything exactly like reset
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      state_q    <= IDLE;
      bx_q       <= 16'd0;
      by_q       <= 16'd0;
      row_addr_q <= 32'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      vis_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      row_addr_q <= row_addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      vis_q      <= vis_d;
    end
  end

  assign idle_o = (state_q == IDLE);
  assign addr_o = row_addr_q;
  assign len_o  = vis_q[2:0] - 3'd1;
  assign data_o = {ALPHA, pix_rgb_i};

endmodule

// File: tb/tb_pixel_burst_gen.sv
// Bench for pixel_burst_gen: a row/column model predicts the ordered stream of
// requests and words per block; a monitor checks every handshake against it.
module tb_pixel_burst_gen;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, idle_o;
  logic [31:0] cfg_base, cfg_stride;
  logic [15:0] cfg_width, cfg_height;
  logic        pix_valid, pix_ready;
  logic [15:0] pix_bx, pix_by;
  logic [23:0] pix_rgb;
  logic        addr_valid, addr_ready;
  logic [31:0] addr_o;
  logic [2:0]  len_o;
  logic        data_valid, data_ready;
  logic [31:0] data_o;

  always #5 clk = ~clk;

  pixel_burst_gen dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .idle_o(idle_o),
    .cfg_base_i(cfg_base), .cfg_stride_i(cfg_stride),
    .cfg_width_i(cfg_width), .cfg_height_i(cfg_height),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .pix_bx_i(pix_bx), .pix_by_i(pix_by), .pix_rgb_i(pix_rgb),
    .addr_valid_o(addr_valid), .addr_ready_i(addr_ready),
    .addr_o(addr_o), .len_o(len_o),
    .data_valid_o(data_valid), .data_ready_i(data_ready), .data_o(data_o)
  );

  typedef struct {
    bit          is_addr;
    logic [31:0] val;
    logic [2:0]  len;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          iters, first_addr, drain;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rgb_of(input logic [7:0] tag, input int p);
    logic [7:0] g, b;
    g = 8'(p * 3);
    b = 8'(p) ^ 8'h5A;
    return {tag, g, b};
  endfunction

  // Expected event stream of one block straight from the clipping rules
  task automatic model_block(input int bx, input int by, input logic [7:0] tag);
    int  bxa, bya, vis, w, h;
    ev_t ev;
    bxa = bx & 32'hFFF8;
    bya = by & 32'hFFF8;
    w   = int'(cfg_width);
    h   = int'(cfg_height);
    if (bxa >= w) vis = 0;
    else if (w - bxa >= 8) vis = 8;
    else vis = w - bxa;
    for (int r = 0; r < 8; r++) begin
      if (vis != 0 && bya + r < h) begin
        ev.is_addr = 1'b1;
        ev.val     = cfg_base + 32'(bya + r) * cfg_stride + 32'(bxa * 4);
        ev.len     = 3'(vis - 1);
        exp_q.push_back(ev);
        for (int c = 0; c < vis; c++) begin
          ev.is_addr = 1'b0;
          ev.val     = {8'hFF, rgb_of(tag, r * 8 + c)};
          ev.len     = 3'd0;
          exp_q.push_back(ev);
        end
      end
    end
  endtask

  // Handshake monitor, sampled 1 time unit before each rising edge
  always @(negedge clk) begin
    ev_t ev;
    #4;
    if (rst_n) begin
      if (addr_valid) chk("pix_ready_in_addr", {31'd0, pix_ready}, 32'd0);
      if (data_valid && !pix_valid) chk("data_valid_without_pix", 32'd1, 32'd0);
      if (addr_valid && addr_ready) begin
        if (exp_q.size() == 0 || !exp_q[0].is_addr) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h len %0d, expected no request", addr_o, len_o);
        end else begin
          ev = exp_q.pop_front();
          chk("req_addr", addr_o, ev.val);
          chk("req_len", {29'd0, len_o}, {29'd0, ev.len});
        end
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0 || exp_q[0].is_addr) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %h, expected no data word", data_o);
        end else begin
          ev = exp_q.pop_front();
          chk("data_word", data_o, ev.val);
        end
      end
    end
  end

  // Present one block; mode 0 full speed, 1 stalled addr + toggling data_ready,
  // 2 data_ready low on the clipped columns. flush_at>=0 flushes after that many pixels.
  task automatic send_block(input int bx, input int by, input logic [7:0] tag,
                            input int mode, input int flush_at,
                            output int n_it, output int f_addr, output int n_drain);
    int p, aw;
    p = 0; aw = 0; n_it = 0; f_addr = -1; n_drain = 0;
    while (p < 64 && n_it < 2000) begin
      @(negedge clk);
      if (flush_at >= 0 && p == flush_at) begin
        pix_valid = 1'b0;
        flush_i   = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush_i = 1'b0;
        #4;
        chk("flush_idle", {31'd0, idle_o}, 32'd1);
        chk("flush_addr_valid", {31'd0, addr_valid}, 32'd0);
        chk("flush_data_valid", {31'd0, data_valid}, 32'd0);
        return;
      end
      pix_valid = 1'b1;
      pix_bx    = (p == 0) ? 16'(bx | 5) : 16'hFFFF;
      pix_by    = (p == 0) ? 16'(by | 3) : 16'hFFFF;
      pix_rgb   = rgb_of(tag, p);
      if (mode == 1) data_ready = cyc[0];
      else if (mode == 2) data_ready = (p % 8 < 4);
      else data_ready = 1'b1;
      if (mode == 1) begin
        if (addr_valid) aw++;
        else aw = 0;
        addr_ready = (aw > 5);
      end else begin
        addr_ready = 1'b1;
      end
      #4;
      if (addr_valid && f_addr < 0) f_addr = n_it;
      if (mode == 2 && p % 8 >= 4) begin
        chk("clipped_col_ready", {31'd0, pix_ready}, 32'd1);
        chk("clipped_col_no_data", {31'd0, data_valid}, 32'd0);
      end
      if (p >= 24) n_drain++;
      if (pix_valid && pix_ready) p++;
      n_it++;
    end
    if (p < 64) begin
      checks++; errors++;
      $display("FAIL pixel_timeout: got %0d pixels accepted, expected 64", p);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    #4;
    chk("block_end_idle", {31'd0, idle_o}, 32'd1);
    chk("block_end_all_events", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; pix_valid = 1'b0;
    pix_bx = 16'd0; pix_by = 16'd0; pix_rgb = 24'd0;
    addr_ready = 1'b1; data_ready = 1'b1;
    cfg_base = 32'h1000_0000; cfg_stride = 32'd256;
    cfg_width = 16'd64; cfg_height = 16'd64;
    repeat (3) @(negedge clk);
    pix_valid = 1'b1;
    @(negedge clk);
    #4;
    chk("reset_idle", {31'd0, idle_o}, 32'd1);
    chk("reset_addr_valid", {31'd0, addr_valid}, 32'd0);
    chk("reset_data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset_pix_ready", {31'd0, pix_ready}, 32'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T1: block (8,16), full image
    model_block(8, 16, 8'd1);
    chk("model_t1_first_addr", exp_q[0].val, 32'h1000_1020);
    chk("model_t1_second_addr", exp_q[9].val, 32'h1000_1120);
    chk("model_t1_first_word", exp_q[1].val, 32'hFF01_005A);
    send_block(8, 16, 8'd1, 0, -1, iters, first_addr, drain);
    chk("t1_first_addr_latency", 32'(first_addr), 32'd2);

    // T2: width 20, block (16,0) -> 4 visible columns
    cfg_width = 16'd20;
    model_block(16, 0, 8'd2);
    chk("model_t2_events", 32'(exp_q.size()), 32'd40);
    chk("model_t2_first_addr", exp_q[0].val, 32'h1000_0040);
    chk("model_t2_len", {29'd0, exp_q[0].len}, 32'd3);
    send_block(16, 0, 8'd2, 2, -1, iters, first_addr, drain);

    // T3: height 19, block (0,16) -> 3 visible rows then 40-pixel drain
    cfg_width = 16'd64; cfg_height = 16'd19;
    model_block(0, 16, 8'd3);
    chk("model_t3_events", 32'(exp_q.size()), 32'd27);
    chk("model_t3_first_addr", exp_q[0].val, 32'h1000_1000);
    send_block(0, 16, 8'd3, 0, -1, iters, first_addr, drain);
    chk("t3_drain_cycles", 32'(drain), 32'd40);

    // T4: T1 under backpressure
    cfg_height = 16'd64;
    model_block(8, 16, 8'd1);
    send_block(8, 16, 8'd1, 1, -1, iters, first_addr, drain);

    // T5: block fully right of the image
    model_block(64, 0, 8'd5);
    chk("model_t5_events", 32'(exp_q.size()), 32'd0);
    send_block(64, 0, 8'd5, 0, -1, iters, first_addr, drain);
    chk("t5_cycles", 32'(iters), 32'd66);

    // T6: flush at row 3 col 2, then a clean T1 block
    model_block(8, 16, 8'd6);
    send_block(8, 16, 8'd6, 0, 26, iters, first_addr, drain);
    model_block(8, 16, 8'd1);
    send_block(8, 16, 8'd1, 0, -1, iters, first_addr, drain);
    chk("t6_first_addr_latency", 32'(first_addr), 32'd2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
